// File: rtl/addsub_pkg.sv
// addsub_pkg: shared constants, flag bundle and saturation helper
// for the segmented add/sub pipeline.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic carry;
    logic ovf;
    logic zero;
    logic neg;
  } flags_t;

  // Clamp value for a w-bit signed result (w <= 64).
  // neg=1 -> most negative, neg=0 -> most positive.
  function automatic logic [63:0] sat_limit(
    input int unsigned w,
    input logic        neg
  );
    logic [63:0] m;
    m = 64'd1 << (w - 1);
    return neg ? m : (m - 64'd1);
  endfunction

endpackage

// File: rtl/addsub_seg.sv
// addsub_seg: registered SEG_W-bit slice adder with carry in/out.
// Ports: clk, rst_n (sync, low), i_en hold enable, i_a/i_b/i_c in, o_s/o_c out.
module addsub_seg
  import addsub_pkg::*;
#(
  parameter int SEG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [SEG_W-1:0] i_a,
  input  logic [SEG_W-1:0] i_b,
  input  logic             i_c,
  output logic [SEG_W-1:0] o_s,
  output logic             o_c
);

  logic [SEG_W:0] w_sum;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b}
               + {{SEG_W{1'b0}}, i_c};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_s <= '0;
      o_c <= 1'b0;
    end else if (i_en) begin
      o_s <= w_sum[SEG_W-1:0];
      o_c <= w_sum[SEG_W];
    end
  end

endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined add/sub, one SEG_W carry segment per stage,
// valid/ready both sides, carry/ovf/zero/neg flags. Macro: ADDSUB_SAT_EN.
// Ports: clk, rst_n, in_valid/in_ready/in_a/in_b/in_op,
// out_valid/out_ready/out_res/out_carry/out_ovf/out_zero/out_neg.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg
);

  localparam int NSEG = WIDTH / SEG_W;
  localparam int MSB  = WIDTH - 1;

  logic                        w_adv;
  logic [WIDTH-1:0]            w_b0;
  logic [NSEG-1:0]             r_v;
  logic [NSEG-1:0][WIDTH-1:0]  r_a;
  logic [NSEG-1:0][WIDTH-1:0]  r_b;
  logic [NSEG-1:0][WIDTH-1:0]  r_res;
  logic [NSEG-1:0][WIDTH-1:0]  w_res;
  logic [NSEG-1:0][SEG_W-1:0]  w_s;
  logic [NSEG-1:0]             w_c;
  logic [WIDTH-1:0]            w_fin;
  logic [WIDTH-1:0]            w_out;
  logic                        w_am;
  logic                        w_bm;
  logic                        w_ovf;
  logic                        w_last_v;
  flags_t                      w_fl;
  logic                        w_unused;

  assign w_adv     = out_ready || !out_valid;
  assign in_ready  = w_adv;
  assign w_b0      = (in_op == OP_SUB) ? ~in_b : in_b;
  assign w_last_v  = r_v[NSEG-1];
  assign out_valid = w_last_v;

  // Only the slice each stage consumes (and the last stage MSB)
  // of the delayed operands is read.
  assign w_unused = ^{r_a, r_b};

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    logic [SEG_W-1:0] w_sa;
    logic [SEG_W-1:0] w_sb;
    logic             w_ci;
    if (k == 0) begin : g_first
      assign w_sa = in_a[SEG_W-1:0];
      assign w_sb = w_b0[SEG_W-1:0];
      assign w_ci = in_op;
    end else begin : g_rest
      assign w_sa = r_a[k-1][k*SEG_W +: SEG_W];
      assign w_sb = r_b[k-1][k*SEG_W +: SEG_W];
      assign w_ci = w_c[k-1];
    end
    addsub_seg #(.SEG_W(SEG_W)) u_seg (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_adv),
      .i_a   (w_sa),
      .i_b   (w_sb),
      .i_c   (w_ci),
      .o_s   (w_s[k]),
      .o_c   (w_c[k])
    );
  end

  // Merge each stage's fresh slice into the completed lower slices.
  always_comb begin
    w_res = r_res;
    for (int k = 0; k < NSEG; k++) begin
      w_res[k][k*SEG_W +: SEG_W] = w_s[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v   <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
    end else if (w_adv) begin
      r_v[0]   <= in_valid;
      r_a[0]   <= in_a;
      r_b[0]   <= w_b0;
      r_res[0] <= '0;
      for (int k = 1; k < NSEG; k++) begin
        r_v[k]   <= r_v[k-1];
        r_a[k]   <= r_a[k-1];
        r_b[k]   <= r_b[k-1];
        r_res[k] <= w_res[k-1];
      end
    end
  end

  assign w_fin = w_res[NSEG-1];
  assign w_am  = r_a[NSEG-1][MSB];
  assign w_bm  = r_b[NSEG-1][MSB];
  assign w_ovf = (w_am == w_bm) && (w_fin[MSB] != w_am);

`ifdef ADDSUB_SAT_EN
  logic [63:0] w_lim;
  logic        w_lim_unused;
  assign w_lim        = sat_limit(WIDTH, w_am);
  assign w_lim_unused = ^w_lim;
  assign w_out        = w_ovf ? w_lim[WIDTH-1:0] : w_fin;
`else
  assign w_out = w_fin;
`endif

  // Flags are forced low while no valid beat sits in the last stage.
  always_comb begin
    w_fl       = '0;
    w_fl.carry = w_last_v & w_c[NSEG-1];
    w_fl.ovf   = w_last_v & w_ovf;
    w_fl.zero  = w_last_v & (w_out == '0);
    w_fl.neg   = w_last_v & w_out[MSB];
  end

  assign out_res   = w_out;
  assign out_carry = w_fl.carry;
  assign out_ovf   = w_fl.ovf;
  assign out_zero  = w_fl.zero;
  assign out_neg   = w_fl.neg;

endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: directed vector table plus stall and
// mid-flight reset sequences for addsub_pipe (16-bit, 4-bit segments).
module tb_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_res;
  logic        out_carry;
  logic        out_ovf;
  logic        out_zero;
  logic        out_neg;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    logic [15:0] res;
    logic [3:0]  fl;
  } vec_t;

  vec_t vecs[9];

  addsub_pipe #(.WIDTH(16), .SEG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_carry (out_carry),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero),
    .out_neg   (out_neg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] a,
                                        input logic [15:0] b,
                                        input logic op);
    logic [16:0] s;
    logic [15:0] bb;
    logic        ov;
    bb = op ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {16'd0, op};
    ov = (a[15] == bb[15]) && (s[15] != a[15]);
`ifdef ADDSUB_SAT_EN
    if (ov) return a[15] ? 16'h8000 : 16'h7FFF;
`else
    if (ov) return s[15:0];
`endif
    return s[15:0];
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    in_a      = v.a;
    in_b      = v.b;
    in_op     = v.op;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk($sformatf("v%0d_in_ready", idx), {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      tick();
      lat++;
    end
    chk($sformatf("v%0d_latency", idx), lat, 32'd4);
    chk($sformatf("v%0d_res", idx), {16'd0, out_res}, {16'd0, v.res});
    chk($sformatf("v%0d_flags_cvzn", idx),
        {28'd0, out_carry, out_ovf, out_zero, out_neg},
        {28'd0, v.fl});
    tick();
  endtask

  initial begin
    logic [15:0] ra[8];
    logic [15:0] rb[8];
    logic        rop[8];
    logic [15:0] q[$];
    logic [15:0] held;
    logic [15:0] e;
    bit          have_held;
    int          sent;
    int          rcvd;
    int          nst;
    int          nv;

    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 4'b0000};
    vecs[1] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 4'b0001};
    vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 4'b1010};
`ifdef ADDSUB_SAT_EN
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 4'b0100};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h8000, 4'b1101};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 4'b1101};
    vecs[7] = '{16'h0000, 16'h8000, 1'b1, 16'h7FFF, 4'b0100};
`else
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b0101};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 4'b1100};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 4'b1110};
    vecs[7] = '{16'h0000, 16'h8000, 1'b1, 16'h8000, 4'b0101};
`endif
    vecs[5] = '{16'h0003, 16'h0003, 1'b1, 16'h0000, 4'b1010};
    vecs[8] = '{16'h00F0, 16'h0F10, 1'b0, 16'h1000, 4'b0000};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_res", {16'd0, out_res}, 32'd0);
    chk("rst_flags",
        {28'd0, out_carry, out_ovf, out_zero, out_neg}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    for (int i = 0; i < 8; i++) begin
      ra[i]  = 16'($urandom);
      rb[i]  = 16'($urandom);
      rop[i] = 1'($urandom_range(0, 1));
    end
    sent      = 0;
    rcvd      = 0;
    nst       = 0;
    have_held = 1'b0;
    held      = '0;
    for (int c = 0; c < 60 && rcvd < 8; c++) begin
      out_ready = !(c >= 5 && c <= 7);
      if (sent < 8) begin
        in_valid = 1'b1;
        in_a     = ra[sent];
        in_b     = rb[sent];
        in_op    = rop[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && !out_ready) begin
        nst++;
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        if (have_held)
          chk("stall_hold", {16'd0, out_res}, {16'd0, held});
        held      = out_res;
        have_held = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (have_held) begin
          chk("stall_release", {16'd0, out_res}, {16'd0, held});
          have_held = 1'b0;
        end
        if (q.size() == 0) begin
          chk("stream_extra", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk($sformatf("stream%0d", rcvd),
              {16'd0, out_res}, {16'd0, e});
        end
        rcvd++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(ra[sent], rb[sent], rop[sent]));
        sent++;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("stream_count", rcvd, 32'd8);
    chk("stall_cycles", nst, 32'd3);

    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a     = 16'h1111 * 16'(i + 1);
      in_b     = 16'h0101;
      in_op    = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_res", {16'd0, out_res}, 32'd0);
    rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) nv++;
      tick();
    end
    chk("midrst_no_stale", nv, 32'd0);
    run_vec('{16'h4321, 16'h1111, 1'b1, 16'h3210, 4'b1000}, 99);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
